weight_stream_mem: RTL and testbench

Double-buffered, runtime-loadable weight memory for one neuron of the fully connected network accelerator. It supersedes the fixed per-neuron weight ROMs. The next layer's weights are written into a shadow bank while the active bank streams its weights to the neuron MAC over a valid/ready handshake. A swap command makes the shadow bank active. The block sits between the weight-load interface and the neuron datapath.

---
 rtl/weight_stream_mem_if.sv | 25 ++
 rtl/weight_stream_mem.sv | 142 ++++++++++++++
 tb/tb_weight_stream_mem.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_mem_if.sv
// Weight-load write port and weight stream handshake for weight_stream_mem.
// slave is the memory side; master is the loader / neuron MAC side.
interface weight_stream_mem_if #(
    parameter int numWeight    = 30,
    parameter int dataWidth    = 16,
    parameter int addressWidth = $clog2(numWeight)
);
    logic                    wen;
    logic [addressWidth-1:0] wadd;
    logic [dataWidth-1:0]    win;
    logic [dataWidth-1:0]    wout;
    logic                    wout_valid;
    logic                    wout_last;
    logic                    wout_ready;

    modport master (
        output wen, wadd, win, wout_ready,
        input  wout, wout_valid, wout_last
    );

    modport slave (
        input  wen, wadd, win, wout_ready,
        output wout, wout_valid, wout_last
    );
endinterface

// File: rtl/weight_stream_mem.sv
// Double-buffered neuron weight memory: loads go to the shadow bank while
// the active bank streams to the MAC over a valid/ready handshake.
module weight_stream_mem #(
    parameter int numWeight    = 30,
    parameter int dataWidth    = 16,
    parameter int addressWidth = $clog2(numWeight)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              swap,
    input  logic              start,
    output logic              busy,
    output logic              active_bank,
    output logic              swap_pending,
    weight_stream_mem_if.slave bus
);

    localparam logic [addressWidth-1:0] LAST_ADDR =
        addressWidth'(numWeight - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [dataWidth-1:0]    r_bank0 [numWeight];
    logic [dataWidth-1:0]    r_bank1 [numWeight];

    logic [addressWidth-1:0] r_ptr;
    logic [addressWidth-1:0] w_ptr_nxt;
    logic [addressWidth-1:0] w_raddr;
    logic                    w_rd_en;
    logic [dataWidth-1:0]    w_rdata;
    logic [dataWidth-1:0]    r_wout;
    logic                    r_valid;
    logic                    w_valid_nxt;
    logic                    r_last;
    logic                    w_last_nxt;
    logic                    r_active;
    logic                    w_active_nxt;
    logic                    r_pend;
    logic                    w_pend_nxt;
    logic                    w_wr_ok;

    assign w_wr_ok = bus.wen && (bus.wadd <= LAST_ADDR);

    // Storage is not reset; writes always land in the bank not being read.
    always_ff @(posedge clk) begin
        if (w_wr_ok && r_active) begin
            r_bank0[bus.wadd] <= bus.win;
        end
        if (w_wr_ok && !r_active) begin
            r_bank1[bus.wadd] <= bus.win;
        end
    end

    always_comb begin
        w_rdata = r_active ? r_bank1[w_raddr] : r_bank0[w_raddr];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_raddr      = r_ptr;
        w_rd_en      = 1'b0;
        w_valid_nxt  = r_valid;
        w_last_nxt   = r_last;
        w_active_nxt = r_active;
        w_pend_nxt   = r_pend;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = STREAM;
                    w_ptr_nxt   = '0;
                    w_raddr     = '0;
                    w_rd_en     = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (LAST_ADDR == '0);
                    w_pend_nxt  = swap;
                end else if (swap) begin
                    w_active_nxt = ~r_active;
                end
            end
            STREAM: begin
                if (swap) begin
                    w_pend_nxt = 1'b1;
                end
                // Next address is fetched straight into the output register
                // on acceptance, so stalls hold and release without bubbles.
                if (r_valid && bus.wout_ready) begin
                    if (r_ptr == LAST_ADDR) begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_pend_nxt  = 1'b0;
                        if (r_pend || swap) begin
                            w_active_nxt = ~r_active;
                        end
                    end else begin
                        w_ptr_nxt  = r_ptr + addressWidth'(1);
                        w_raddr    = w_ptr_nxt;
                        w_rd_en    = 1'b1;
                        w_last_nxt = (w_ptr_nxt == LAST_ADDR);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_active <= 1'b0;
            r_pend   <= 1'b0;
            r_wout   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_valid  <= w_valid_nxt;
            r_last   <= w_last_nxt;
            r_active <= w_active_nxt;
            r_pend   <= w_pend_nxt;
            if (w_rd_en) begin
                r_wout <= w_rdata;
            end
        end
    end

    assign bus.wout       = r_wout;
    assign bus.wout_valid = r_valid;
    assign bus.wout_last  = r_last;
    assign busy           = (r_state == STREAM);
    assign active_bank    = r_active;
    assign swap_pending   = r_pend;

endmodule

// File: tb/tb_weight_stream_mem.sv
// Bench for weight_stream_mem: table of load/swap/stream runs plus
// hand-written swap, shadow-write, coincidence and reset sequences.
module tb_weight_stream_mem;

    localparam int N  = 30;
    localparam int DW = 16;
    localparam int AW = $clog2(N);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic swap = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic active_bank;
    logic swap_pending;

    weight_stream_mem_if #(
        .numWeight(N), .dataWidth(DW), .addressWidth(AW)
    ) bus ();

    weight_stream_mem #(
        .numWeight(N), .dataWidth(DW), .addressWidth(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .swap(swap),
        .start(start),
        .busy(busy),
        .active_bank(active_bank),
        .swap_pending(swap_pending),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] base;
        logic [DW-1:0] step;
        bit            bp;
        logic          exp_bank;
    } vec_t;

    beat_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    rmode = 1'b0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Scoreboard: pop one expected beat per accepted handshake.
    logic          prev_stall = 1'b0;
    logic [DW+1:0] prev_out = '0;
    always @(negedge clk) begin
        beat_t b;
        if (rst && prev_stall) begin
            check("hold_stable",
                  {bus.wout, bus.wout_valid, bus.wout_last}, prev_out);
        end
        prev_stall <= rst && bus.wout_valid && !bus.wout_ready;
        prev_out   <= {bus.wout, bus.wout_valid, bus.wout_last};
        if (rst && bus.wout_valid && bus.wout_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_beat: got %0h required none",
                         bus.wout);
            end else begin
                b = q.pop_front();
                check("beat_data", bus.wout, b.data);
                check("beat_last", bus.wout_last, b.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.wout_ready = rmode ? (cyc % 3 == 0) : 1'b1;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bus.wen  = 1'b1;
        bus.wadd = AW'(a);
        bus.win  = d;
        tick();
        bus.wen  = 1'b0;
    endtask

    task automatic load_shadow(input logic [DW-1:0] base,
                               input logic [DW-1:0] step);
        for (int i = 0; i < N; i++) wr(i, DW'(base + i * step));
    endtask

    task automatic push_stream(input logic [DW-1:0] base,
                               input logic [DW-1:0] step);
        beat_t b;
        for (int i = 0; i < N; i++) begin
            b.data = DW'(base + i * step);
            b.last = (i == N - 1);
            q.push_back(b);
        end
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
    endtask

    task automatic start_stream();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    vec_t vecs[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd0,     16'd3, 1'b0, 1'b1};
        vecs[1] = '{16'd0,     16'd3, 1'b1, 1'b0};
        vecs[2] = '{16'd100,   16'd7, 1'b0, 1'b1};
        vecs[3] = '{16'hFFF0,  16'd1, 1'b1, 1'b0};

        bus.wen        = 1'b0;
        bus.wadd       = '0;
        bus.win        = '0;
        bus.wout_ready = 1'b1;

        tick();
        tick();
        check("rst_wout", bus.wout, 0);
        check("rst_valid", bus.wout_valid, 0);
        check("rst_last", bus.wout_last, 0);
        check("rst_busy", busy, 0);
        check("rst_bank", active_bank, 0);
        check("rst_pend", swap_pending, 0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            load_shadow(vecs[v].base, vecs[v].step);
            pulse_swap();
            check("vec_bank", active_bank, vecs[v].exp_bank);
            check("vec_pend", swap_pending, 0);
            rmode = vecs[v].bp;
            push_stream(vecs[v].base, vecs[v].step);
            start_stream();
            check("vec_busy_t1", busy, 1);
            check("vec_valid_t1", bus.wout_valid, 1);
            if (!vecs[v].bp) begin
                repeat (N - 1) tick();
                check("vec_busy_tN", busy, 1);
                tick();
                check("vec_busy_end", busy, 0);
                check("vec_valid_end", bus.wout_valid, 0);
            end else begin
                wait_idle("vec_bp_idle");
            end
            rmode = 1'b0;
            tick();
            check("vec_drained", q.size(), 0);
        end

        // Swap twice mid-stream: one deferred toggle.
        load_shadow(16'd200, 16'd1);
        pulse_swap();
        load_shadow(16'd100, 16'd1);
        check("ss_bank_before", active_bank, 1);
        push_stream(16'd200, 16'd1);
        start_stream();
        repeat (5) tick();
        swap = 1'b1;
        tick();
        tick();
        swap = 1'b0;
        check("ss_pend", swap_pending, 1);
        repeat (10) tick();
        check("ss_pend_hold", swap_pending, 1);
        check("ss_bank_hold", active_bank, 1);
        wait_idle("ss_idle");
        check("ss_bank_after", active_bank, 0);
        check("ss_pend_after", swap_pending, 0);

        // Shadow writes during a stream, including out-of-range address.
        pulse_swap();
        check("sw_bank", active_bank, 1);
        push_stream(16'd200, 16'd1);
        start_stream();
        for (int a = 0; a < N; a++) wr(a, 16'hFFFF);
        wr(31, 16'hFFFF);
        wr(31, 16'h1234);
        wait_idle("sw_idle");
        pulse_swap();
        check("sw_bank2", active_bank, 0);
        push_stream(16'hFFFF, 16'd0);
        start_stream();
        wait_idle("sw_idle2");

        // start+swap together, then an ignored start mid-stream.
        swap  = 1'b1;
        start = 1'b1;
        push_stream(16'hFFFF, 16'd0);
        tick();
        swap  = 1'b0;
        start = 1'b0;
        check("co_pend", swap_pending, 1);
        check("co_bank", active_bank, 0);
        check("co_busy", busy, 1);
        repeat (10) tick();
        start_stream();
        wait_idle("co_idle");
        check("co_bank_after", active_bank, 1);
        check("co_pend_after", swap_pending, 0);
        repeat (3) tick();
        check("co_no_restart", busy, 0);
        check("co_drained", q.size(), 0);

        // Reset at beat 10 with a swap pending.
        load_shadow(16'd300, 16'd1);
        push_stream(16'd200, 16'd1);
        start_stream();
        repeat (2) tick();
        pulse_swap();
        repeat (7) tick();
        check("rm_pend", swap_pending, 1);
        check("rm_beat10", bus.wout, 16'd210);
        rst = 1'b0;
        tick();
        check("rm_wout", bus.wout, 0);
        check("rm_valid", bus.wout_valid, 0);
        check("rm_last", bus.wout_last, 0);
        check("rm_busy", busy, 0);
        check("rm_bank", active_bank, 0);
        check("rm_pend_clr", swap_pending, 0);
        q.delete();
        rst = 1'b1;
        tick();
        push_stream(16'd300, 16'd1);
        start_stream();
        check("rm_first", bus.wout, 16'd300);
        wait_idle("rm_idle");
        check("rm_bank_end", active_bank, 0);

        tick();
        check("final_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
